// File: rtl/axi_fetch_pkg.sv
// Shared types and constants for the AXI instruction-fetch master.
package axi_fetch_pkg;

    localparam int unsigned AXI_ID_BITS   = 4;
    localparam int unsigned AXI_ADDR_BITS = 32;
    localparam int unsigned AXI_DATA_BITS = 32;
    localparam int unsigned AXI_LEN_BITS  = 8;
    localparam int unsigned AXI_SIZE_BITS = 3;
    localparam int unsigned TAG_BITS      = 30;

    localparam logic [AXI_SIZE_BITS-1:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0]               BURST_INCR = 2'b01;
    localparam logic [1:0]               RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_DATA_BITS-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } axi_r_beat_t;

    // Word tag of a byte address.
    function automatic logic [TAG_BITS-1:0] word_tag(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/axi_im_fetch_master.sv
// Single-word AXI read master for CPU instruction fetch with a one-entry
// hit register that short-circuits repeat fetches of the last good word.
module axi_im_fetch_master
    import axi_fetch_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     cpu_req,
    input  logic [31:0]              cpu_addr,
    output logic                     cpu_stall,
    output logic                     cpu_done,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_err,
    output logic [AXI_ID_BITS-1:0]   ARID,
    output logic [AXI_ADDR_BITS-1:0] ARADDR,
    output logic [AXI_LEN_BITS-1:0]  ARLEN,
    output logic [AXI_SIZE_BITS-1:0] ARSIZE,
    output logic [1:0]               ARBURST,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [AXI_ID_BITS-1:0]   RID,
    input  logic [AXI_DATA_BITS-1:0] RDATA,
    input  logic [1:0]               RRESP,
    input  logic                     RLAST,
    input  logic                     RVALID,
    output logic                     RREADY
);

    fetch_state_e        state, state_n;
    logic                hit_valid;
    logic [TAG_BITS-1:0] hit_tag;
    axi_r_beat_t         r_beat;
    logic                hit_c, miss_c, beat_c, beat_err_c;
    logic                unused_addr_lsbs;

    assign ARID    = MASTER_ID;
    assign ARLEN   = '0;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;

    assign r_beat = '{id: RID, data: RDATA, resp: RRESP, last: RLAST};

    // Byte offset never reaches the bus; fetches are word aligned.
    assign unused_addr_lsbs = ^cpu_addr[1:0];

    assign cpu_stall = (cpu_req & ~cpu_done) | (state != ST_IDLE);

    // Next-state and per-cycle event decode.
    always_comb begin
        state_n    = state;
        hit_c      = 1'b0;
        miss_c     = 1'b0;
        beat_c     = 1'b0;
        beat_err_c = (r_beat.resp != RESP_OKAY) | (r_beat.id != MASTER_ID) | ~r_beat.last;
        case (state)
            ST_IDLE: begin
                if (cpu_req && !cpu_done) begin
                    if (hit_valid && (word_tag(cpu_addr) == hit_tag)) begin
                        hit_c = 1'b1;
                    end else begin
                        miss_c  = 1'b1;
                        state_n = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (ARREADY) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (RVALID) begin
                    beat_c  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, registered Moore handshake outputs, CPU result and hit register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            ARADDR    <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            hit_valid <= 1'b0;
            hit_tag   <= '0;
        end else begin
            state    <= state_n;
            ARVALID  <= (state_n == ST_ADDR);
            RREADY   <= (state_n == ST_DATA);
            cpu_done <= hit_c | beat_c;
            if (hit_c) begin
                cpu_err <= 1'b0;
            end
            if (miss_c) begin
                ARADDR <= {cpu_addr[31:2], 2'b00};
            end
            if (beat_c) begin
                cpu_rdata <= r_beat.data;
                cpu_err   <= beat_err_c;
                if (beat_err_c) begin
                    hit_valid <= 1'b0;
                end else begin
                    hit_valid <= 1'b1;
                    hit_tag   <= ARADDR[31:2];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_im_fetch_master.sv
// Self-checking bench: directed scenarios plus randomized fetches against a
// transaction-level model of the one-entry hit register.
module tb_axi_im_fetch_master;
    import axi_fetch_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic [AXI_ID_BITS-1:0]   ARID, RID;
    logic [AXI_ADDR_BITS-1:0] ARADDR;
    logic [AXI_LEN_BITS-1:0]  ARLEN;
    logic [AXI_SIZE_BITS-1:0] ARSIZE;
    logic [1:0]  ARBURST, RRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [AXI_DATA_BITS-1:0] RDATA;

    int errors = 0;
    int checks = 0;

    // Reference model: one cached word tag plus the last data returned by AXI.
    bit          m_valid;
    logic [29:0] m_tag;
    logic [31:0] m_rdata;

    axi_im_fetch_master #(.MASTER_ID(4'd0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_tag   = '0;
        m_rdata = '0;
    endtask

    // One CPU fetch with a scripted slave; b2b means the request is raised in
    // the cycle the previous cpu_done is showing, so it cannot be taken yet.
    task automatic run_fetch(input logic [31:0] addr, input int ard, input int rd,
                             input logic [1:0] resp, input logic [3:0] rid,
                             input logic last, input logic [31:0] data,
                             input bit early, input bit b2b);
        bit          hit, done, stall_bad, araddr_bad, hs;
        logic        exp_err, got_err;
        logic [31:0] exp_data, got_rd;
        int          exp_lat, c, nar, av_cycles, ar_seen, r_seen;

        hit      = m_valid && (addr[31:2] == m_tag);
        exp_err  = hit ? 1'b0 : ((resp != 2'b00) || (rid != 4'd0) || !last);
        exp_data = hit ? m_rdata : data;
        exp_lat  = (b2b ? 1 : 0) + (hit ? 1 : 3 + ard + rd);

        cpu_req = 1'b1; cpu_addr = addr;
        ARREADY = 1'b0; RVALID = 1'b0;
        RID = rid; RRESP = resp; RLAST = last; RDATA = data;
        done = 0; stall_bad = 0; araddr_bad = 0; got_err = 1'bx; got_rd = 'x;
        c = 0; nar = 0; av_cycles = 0; ar_seen = 0; r_seen = 0;

        while (!done && c < 300) begin
            hs = ARVALID && ARREADY;
            step();
            c++;
            if (hs) nar++;
            if (cpu_done) begin
                done = 1; got_rd = cpu_rdata; got_err = cpu_err;
                if (cpu_stall !== 1'b0) stall_bad = 1;
            end else if (cpu_stall !== 1'b1) begin
                stall_bad = 1;
            end
            ARREADY = 1'b0; RVALID = 1'b0; RDATA = data;
            if (!done && ARVALID) begin
                av_cycles++;
                if (ARADDR !== {addr[31:2], 2'b00}) araddr_bad = 1;
                ARREADY = (ar_seen >= ard);
                ar_seen++;
                if (early) begin
                    RVALID = 1'b1; RDATA = ~data;
                end
            end else if (!done && RREADY) begin
                RVALID = (r_seen >= rd);
                r_seen++;
            end
        end
        cpu_req = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;

        check("fetch_completes", 64'(done), 64'd1);
        if (done) begin
            check("latency", 64'(c), 64'(exp_lat));
            check("ar_handshakes", 64'(nar), hit ? 64'd0 : 64'd1);
            check("arvalid_cycles", 64'(av_cycles), hit ? 64'd0 : 64'(ard + 1));
            check("cpu_rdata", 64'(got_rd), 64'(exp_data));
            check("cpu_err", 64'(got_err), 64'(exp_err));
            check("araddr_stable", 64'(araddr_bad), 64'd0);
            check("cpu_stall", 64'(stall_bad), 64'd0);
        end

        if (!hit) begin
            m_rdata = data;
            if (exp_err) begin
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_tag   = addr[31:2];
            end
        end
    endtask

    initial begin
        int          nidle;
        bit          bad;
        logic [31:0] a, d;
        logic [1:0]  resp;
        logic [3:0]  rid;
        logic        last;

        ARESET = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b1;
        model_reset();
        step(); step();
        ARESET = 1'b0;

        check("rst_arvalid", 64'(ARVALID), 64'd0);
        check("rst_rready", 64'(RREADY), 64'd0);
        check("rst_cpu_done", 64'(cpu_done), 64'd0);
        check("rst_cpu_err", 64'(cpu_err), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_araddr", 64'(ARADDR), 64'd0);
        check("rst_cpu_stall", 64'(cpu_stall), 64'd0);
        check("arid", 64'(ARID), 64'd0);
        check("arlen", 64'(ARLEN), 64'd0);
        check("arsize", 64'(ARSIZE), 64'd2);
        check("arburst", 64'(ARBURST), 64'd1);

        // Basic miss, repeat hit, slow ARREADY, error responses.
        run_fetch(32'h10, 0, 0, 2'b00, 4'd0, 1'b1, 32'h1234_5678, 0, 0);
        step();
        run_fetch(32'h12, 0, 0, 2'b00, 4'd0, 1'b1, 32'hdead_beef, 0, 0);
        step();
        run_fetch(32'h20, 5, 1, 2'b11, 4'd0, 1'b1, 32'h0bad_0001, 0, 0);
        step();
        run_fetch(32'h20, 0, 0, 2'b00, 4'd0, 1'b1, 32'h2020_2020, 0, 0);
        step();
        run_fetch(32'h30, 0, 0, 2'b00, 4'd1, 1'b1, 32'h3030_3030, 0, 0);
        run_fetch(32'h30, 2, 0, 2'b00, 4'd0, 1'b1, 32'h3131_3131, 1, 1);
        run_fetch(32'h34, 0, 2, 2'b00, 4'd0, 1'b0, 32'h3434_3434, 1, 1);
        step();

        // Reset while a read is outstanding in the data phase.
        run_fetch(32'h40, 0, 0, 2'b00, 4'd0, 1'b1, 32'h4040_4040, 0, 0);
        step();
        cpu_req = 1'b1; cpu_addr = 32'h80; ARREADY = 1'b1;
        step();
        step();
        ARREADY = 1'b0;
        check("pre_reset_rready", 64'(RREADY), 64'd1);
        ARESET = 1'b1; cpu_req = 1'b0;
        step();
        ARESET = 1'b0;
        model_reset();
        check("mid_rst_rready", 64'(RREADY), 64'd0);
        check("mid_rst_arvalid", 64'(ARVALID), 64'd0);
        check("mid_rst_cpu_done", 64'(cpu_done), 64'd0);
        check("mid_rst_idle", 64'(cpu_stall), 64'd0);
        check("mid_rst_rdata", 64'(cpu_rdata), 64'd0);
        bad = 0;
        RVALID = 1'b1; RDATA = 32'h8080_8080;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpu_done || RREADY || ARVALID) bad = 1;
        end
        RVALID = 1'b0;
        check("no_done_after_reset", 64'(bad), 64'd0);
        run_fetch(32'h40, 0, 0, 2'b00, 4'd0, 1'b1, 32'h4141_4141, 0, 0);

        // Randomized fetches over a small address pool to mix hits and misses.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) a = $urandom;
            else a = 32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            d = $urandom;
            resp = 2'b00; rid = 4'd0; last = 1'b1;
            case ($urandom_range(0, 9))
                0: resp = 2'($urandom_range(1, 3));
                1: rid  = 4'($urandom_range(1, 15));
                2: last = 1'b0;
                default: ;
            endcase
            nidle = $urandom_range(0, 2);
            for (int i = 0; i < nidle; i++) step();
            run_fetch(a, $urandom_range(0, 4), $urandom_range(0, 4), resp, rid, last, d,
                      ($urandom_range(0, 3) == 0), (nidle == 0));
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_im_fetch_master.md
AXI_IM_FETCH_MASTER -- requirements
Module: axi_im_fetch_master

Interface
REQ-001 The block SHALL have one clock, ACLK, and one reset, ARESET, which is synchronous and active-high.
REQ-002 Parameter: MASTER_ID, default 0, the value driven on ARID.
REQ-003 ACLK  in  1  clock.
REQ-004 ARESET  in  1  synchronous active-high reset.
REQ-005 cpu_req  in  1  CPU instruction-fetch request, held until cpu_done.
REQ-006 cpu_addr  in  32  CPU byte address, held stable while cpu_req=1.
REQ-007 cpu_stall  out  1  asserted while a fetch is pending and not yet done.
REQ-008 cpu_done  out  1  one-cycle completion pulse.
REQ-009 cpu_rdata  out  32  fetched instruction.
REQ-010 cpu_err  out  1  completion carried an error; valid with cpu_done.
REQ-011 ARID  out  `AXI_ID_BITS  read ID, equal to MASTER_ID.
REQ-012 ARADDR  out  `AXI_ADDR_BITS  read address.
REQ-013 ARLEN/ARSIZE/ARBURST  out  `AXI_LEN_BITS/`AXI_SIZE_BITS/2  constant values 0 / 3'b010 / 2'b01 (INCR).
REQ-014 ARVALID  out  1; ARREADY  in  1.
REQ-015 RID  in  `AXI_ID_BITS; RDATA  in  `AXI_DATA_BITS; RRESP  in  2; RLAST  in  1.
REQ-016 RVALID  in  1; RREADY  out  1.

Function
REQ-017 The state machine SHALL have three states, IDLE, ADDR and DATA, and SHALL be Moore-style for ARVALID and RREADY.
REQ-018 In IDLE, when cpu_req=1 and cpu_done=0:
- on a hit (hit_valid=1 and cpu_addr[31:2]==hit_tag), the block SHALL assert cpu_done with cpu_err=0 on the next cycle and issue no AXI traffic;
- on a miss, it SHALL latch cpu_addr and go to ADDR.
REQ-019 In ADDR, ARVALID=1 and ARADDR={latched[31:2],2'b00}; both SHALL be held stable until the cycle ARVALID&ARREADY, then the block SHALL go to DATA.
REQ-020 In DATA, RREADY=1; on RVALID the block SHALL capture RDATA into cpu_rdata and return to IDLE, with cpu_done=1 on the next cycle.
REQ-021 The error condition SHALL be computed on the RVALID beat as cpu_err = (RRESP!=2'b00) | (RID!=MASTER_ID) | ~RLAST.
REQ-022 On an error-free completion, hit_tag SHALL be set to the latched address[31:2] and hit_valid=1; on an erroring completion, hit_valid SHALL be set to 0.
REQ-023 cpu_stall SHALL equal (cpu_req & ~cpu_done) | (state!=IDLE).
REQ-024 cpu_rdata SHALL hold its value until the next AXI completion; a hit SHALL NOT modify it.
REQ-025 A request SHALL NOT be accepted in the cycle cpu_done=1, so the minimum miss-to-miss spacing is one idle cycle; the minimum miss latency is 3 cycles from request to cpu_done.
REQ-026 ARREADY and RVALID arriving in the same cycle while in ADDR: RVALID SHALL be ignored, and the block SHALL accept the beat in DATA.
REQ-027 ARREADY=1 in the same cycle ARVALID first rises SHALL complete the handshake in that cycle.
REQ-028 There SHALL be no timeout; the block SHALL wait indefinitely for ARREADY or RVALID.

Reset
REQ-029 While ARESET=1 at a clock edge: state=IDLE, ARVALID=0, RREADY=0, cpu_done=0, cpu_err=0, cpu_rdata=0, hit_valid=0, hit_tag=0, ARADDR=0.
REQ-030 A reset asserted mid-transaction SHALL abandon the transfer at the next edge, and no cpu_done SHALL be produced for it.

Structure
REQ-031 The package axi_fetch_pkg SHALL hold the state enum, SIZE_WORD=3'b010, BURST_INCR=2'b01 and RESP_OKAY=2'b00.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Reset, then cpu_req=1 with cpu_addr=0x0000_0010, ARREADY=1 at once, RVALID one cycle later with RDATA=0x1234_5678, RRESP=0, RID=0, RLAST=1 -> ARADDR=0x10, cpu_done with cpu_rdata=0x1234_5678 and cpu_err=0, 3 cycles after the request.
REQ-034 ARREADY held low for 5 cycles -> ARVALID and ARADDR stable for all 6 cycles, and exactly one handshake.
REQ-035 A repeat fetch of 0x12 after REQ-033 -> cpu_done next cycle, ARVALID stays 0, cpu_rdata=0x1234_5678.
REQ-036 RRESP=2'b11 on fetch of 0x20 -> cpu_err=1; a subsequent fetch of 0x20 misses and issues an AXI read.
REQ-037 ARESET asserted while in DATA -> next cycle state IDLE, RREADY=0, cpu_done=0, hit_valid=0.
REQ-038 RID=1 with RRESP=0 -> cpu_err=1.
